switch_debouncer: RTL and testbench

- Input-side conditioner for the raw switch bank. Produces the clean, synchronised, debounced `in` bus that the LED logic consumes.
- Per-bit two-stage synchroniser, then a per-bit stability counter.
- Emits per-bit rise/fall pulses and an accumulated change-event mask on a valid/ready handshake toward a consumer.

---
 rtl/switch_debouncer.sv | 154 +++++++++++++++
 tb/tb_switch_debouncer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit synchroniser + stability-counter debouncer for a
// bank of raw switch lines. Emits registered rise/fall pulses and an
// accumulated change mask offered to a consumer on a valid/ready handshake.
// Optional build macro DEBOUNCE_OVF_EN adds a sticky lost-edge flag
// (o_evt_ovf); without it o_evt_ovf is tied low.
module switch_debouncer #(
   parameter int WIDTH           = 14,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SYNC_STAGES     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_sw,
   output logic [WIDTH-1:0] o_sw,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic             o_evt_valid,
   output logic [WIDTH-1:0] o_evt_mask,
   input  logic             i_evt_ready,
   output logic             o_evt_ovf
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_IDLE,
      ST_PEND
   } state_e;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   state_e           state_q [WIDTH];
   state_e           state_d [WIDTH];
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   logic [WIDTH-1:0] sw_q, sw_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] commit;
   logic             xfer;

   // Synchroniser chain: pure flop-to-flop shift, no logic in between.
   always_comb begin
      sync_d[0] = i_sw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Per-bit stability FSM: count consecutive mismatches, commit on the last one.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = '0;
      for (int b = 0; b < WIDTH; b++) begin
         case (state_q[b])
            ST_IDLE: begin
               if (s[b] != sw_q[b]) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     commit[b] = 1'b1;
                  end else begin
                     state_d[b] = ST_PEND;
                     cnt_d[b]   = CNT_W'(1);
                  end
               end
            end
            default: begin
               if (s[b] == sw_q[b]) begin
                  state_d[b] = ST_IDLE;
                  cnt_d[b]   = '0;
               end else if (cnt_q[b] == CNT_LAST) begin
                  commit[b]  = 1'b1;
                  state_d[b] = ST_IDLE;
                  cnt_d[b]   = '0;
               end else begin
                  cnt_d[b] = cnt_q[b] + CNT_W'(1);
               end
            end
         endcase
      end
   end

   // Commit side effects and event-mask accumulation / handoff.
   always_comb begin
      xfer    = valid_q & i_evt_ready;
      sw_d    = sw_q ^ commit;
      rise_d  = commit & ~sw_q;
      fall_d  = commit & sw_q;
      // A transfer hands off the old mask; this edge's commits start the next one.
      mask_d  = xfer ? commit : (mask_q | commit);
      valid_d = |mask_d;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         for (int b = 0; b < WIDTH; b++) begin
            state_q[b] <= ST_IDLE;
            cnt_q[b]   <= '0;
         end
         sw_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sw_q    <= sw_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
      end
   end

`ifdef DEBOUNCE_OVF_EN
   logic ovf_q, ovf_d;

   // Sticky overflow: a commit landed on a mask bit still awaiting handoff.
   always_comb begin
      ovf_d = (ovf_q & ~xfer) | (~xfer & (|(commit & mask_q)));
   end

   // Overflow flag register.
   always_ff @(posedge clk) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign o_evt_ovf = ovf_q;
`else
   assign o_evt_ovf = 1'b0;
`endif

   assign o_sw        = sw_q;
   assign o_rise      = rise_q;
   assign o_fall      = fall_q;
   assign o_evt_mask  = mask_q;
   assign o_evt_valid = valid_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed stimulus for switch_debouncer (WIDTH=14,
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2) with a per-cycle reference model and
// literal expectations at the key points of each scenario.
module tb_switch_debouncer;

   localparam int W = 14;
   localparam int D = 4;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] i_sw = '0;
   logic         i_evt_ready = 1'b0;
   logic [W-1:0] o_sw, o_rise, o_fall, o_evt_mask;
   logic         o_evt_valid, o_evt_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   switch_debouncer #(
      .WIDTH(W), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_sw(i_sw),
      .o_sw(o_sw), .o_rise(o_rise), .o_fall(o_fall),
      .o_evt_valid(o_evt_valid), .o_evt_mask(o_evt_mask),
      .i_evt_ready(i_evt_ready), .o_evt_ovf(o_evt_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each bit commits once it has seen D consecutive synchronised samples that
   // disagree with its debounced value; the sample seen on an edge is the raw
   // input captured S edges earlier (zero right after reset).
   logic [W-1:0] m_line [S];
   int           m_run [W];
   logic [W-1:0] m_sw = '0, m_rise = '0, m_fall = '0, m_mask = '0;
   logic         m_valid = 1'b0, m_ovf = 1'b0;
   logic [W-1:0] m_seen, m_c;
   logic         m_xfer;

   initial begin
      for (int i = 0; i < S; i++) m_line[i] = '0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < S; i++) m_line[i] = '0;
         for (int b = 0; b < W; b++) m_run[b] = 0;
         m_sw = '0; m_rise = '0; m_fall = '0; m_mask = '0;
         m_valid = 1'b0; m_ovf = 1'b0;
      end else begin
         m_seen = m_line[S-1];
         for (int i = S-1; i > 0; i--) m_line[i] = m_line[i-1];
         m_line[0] = i_sw;
         m_c = '0;
         for (int b = 0; b < W; b++) begin
            if (m_seen[b] != m_sw[b]) begin
               m_run[b]++;
               if (m_run[b] == D) begin
                  m_c[b] = 1'b1;
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_xfer = m_valid && i_evt_ready;
`ifdef DEBOUNCE_OVF_EN
         if (m_xfer) m_ovf = 1'b0;
         else if ((m_c & m_mask) != '0) m_ovf = 1'b1;
`endif
         m_rise = m_c & ~m_sw;
         m_fall = m_c & m_sw;
         m_sw   = m_sw ^ m_c;
         m_mask = m_xfer ? m_c : (m_mask | m_c);
         m_valid = (m_mask != '0);
      end
   end

   // Compare every cycle, 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      check("cyc_o_sw",        32'(o_sw),        32'(m_sw));
      check("cyc_o_rise",      32'(o_rise),      32'(m_rise));
      check("cyc_o_fall",      32'(o_fall),      32'(m_fall));
      check("cyc_o_evt_mask",  32'(o_evt_mask),  32'(m_mask));
      check("cyc_o_evt_valid", 32'(o_evt_valid), 32'(m_valid));
      check("cyc_o_evt_ovf",   32'(o_evt_ovf),   32'(m_ovf));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; i_sw = '0; i_evt_ready = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   // Counts edges (seen at following negedges) until all bits in m read 1.
   task automatic wait_sw(input logic [W-1:0] m, input int exp_n, input string name);
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 20) begin
         @(negedge clk);
         n++;
         if ((o_sw & m) == m) hit = 1'b1;
      end
      if (!hit) n = 99;
      check(name, n, exp_n);
   endtask

   logic [W-1:0] acc;
   logic         acc_v;

   initial begin
      // 1: inputs high through reset, release, full-latency rise on all bits
      rst_n = 1'b0; i_sw = 14'h3FFF;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("t1_rst_sw",    32'(o_sw),        0);
         check("t1_rst_rise",  32'(o_rise),      0);
         check("t1_rst_valid", 32'(o_evt_valid), 0);
         check("t1_rst_mask",  32'(o_evt_mask),  0);
         check("t1_rst_ovf",   32'(o_evt_ovf),   0);
      end
      rst_n = 1'b1;
      wait_sw(14'h3FFF, 6, "t1_latency");
      check("t1_sw",    32'(o_sw),        32'h3FFF);
      check("t1_rise",  32'(o_rise),      32'h3FFF);
      check("t1_mask",  32'(o_evt_mask),  32'h3FFF);
      check("t1_valid", 32'(o_evt_valid), 1);
      tick(1);
      check("t1_rise_once", 32'(o_rise), 0);

      // 2: single-bit rise
      do_reset();
      i_sw = 14'h0001;
      wait_sw(14'h0001, 6, "t2_latency");
      check("t2_rise", 32'(o_rise),     32'h0001);
      check("t2_fall", 32'(o_fall),     0);
      check("t2_mask", 32'(o_evt_mask), 32'h0001);
      tick(1);
      check("t2_rise_once", 32'(o_rise), 0);

      // 3: 3-cycle glitch is rejected
      do_reset();
      i_sw = 14'h0008;
      acc = '0; acc_v = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (k == 3) i_sw = '0;
         tick(1);
         acc   = acc | o_sw | o_rise | o_fall;
         acc_v = acc_v | o_evt_valid;
      end
      check("t3_glitch_out",   32'(acc),   0);
      check("t3_glitch_valid", 32'(acc_v), 0);

      // 4: handshake with a commit on the transfer edge
      do_reset();
      i_sw = 14'h0002;
      tick(2);
      i_sw = 14'h0022;
      tick(10);
      check("t4_mask_acc", 32'(o_evt_mask),  32'h0022);
      check("t4_valid",    32'(o_evt_valid), 1);
      i_sw = 14'h00A2;
      tick(5);
      i_evt_ready = 1'b1;
      tick(1);
      i_evt_ready = 1'b0;
      check("t4_sw7",        32'(o_sw[7]),     1);
      check("t4_mask_xfer",  32'(o_evt_mask),  32'h0080);
      check("t4_valid_kept", 32'(o_evt_valid), 1);
      i_evt_ready = 1'b1;
      tick(1);
      i_evt_ready = 1'b0;
      check("t4_valid_drop", 32'(o_evt_valid), 0);
      check("t4_mask_clear", 32'(o_evt_mask),  0);

      // 5: same bit commits twice before acceptance
      do_reset();
      i_sw = 14'h0004;
      tick(8);
      i_sw = '0;
      tick(10);
      check("t5_mask", 32'(o_evt_mask), 32'h0004);
`ifdef DEBOUNCE_OVF_EN
      check("t5_ovf", 32'(o_evt_ovf), 1);
`else
      check("t5_ovf", 32'(o_evt_ovf), 0);
`endif
      i_evt_ready = 1'b1;
      tick(1);
      i_evt_ready = 1'b0;
      check("t5_valid_clr", 32'(o_evt_valid), 0);
      check("t5_ovf_clr",   32'(o_evt_ovf),   0);

      // 6: reset in the middle of a pending count
      do_reset();
      i_sw = 14'h0010;
      tick(4);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("t6_sw",    32'(o_sw),        0);
      check("t6_rise",  32'(o_rise),      0);
      check("t6_valid", 32'(o_evt_valid), 0);
      wait_sw(14'h0010, 6, "t6_latency");
      check("t6_rise_after", 32'(o_rise), 32'h0010);
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound in case a scenario stalls.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, limit 100000 reached");
      $fatal(1);
   end

endmodule
